// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle control FSM.
//   state_t       FSM state encoding
//   alu_op_t      ULA operation select
//   sel_a_t       ULA operand A mux select
//   sel_b_t       ULA operand B mux select
//   trap_cause_t  reason latched on entry to TRAP
//   ctl_t         bundle of every datapath control output
//   alu_decode()  funct3/funct7_5 to ALU op for R/I arithmetic
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StLui,
        StAddr,
        StMemRd,
        StMemWr,
        StWbAlu,
        StWbMem,
        StBranch,
        StPcInc,
        StTrap
    } state_t;

    typedef enum logic [2:0] {
        AluAdd   = 3'b000,
        AluSub   = 3'b001,
        AluAnd   = 3'b010,
        AluOr    = 3'b011,
        AluXor   = 3'b100,
        AluPassB = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        SelAPc   = 2'b00,
        SelAReg  = 2'b01,
        SelAZero = 2'b10
    } sel_a_t;

    typedef enum logic [1:0] {
        SelBReg    = 2'b00,
        SelBFour   = 2'b01,
        SelBImm    = 2'b10,
        SelBImmSh1 = 2'b11
    } sel_b_t;

    typedef enum logic [1:0] {
        CauseNone    = 2'b00,
        CauseIllegal = 2'b01,
        CauseImemTo  = 2'b10,
        CauseDmemTo  = 2'b11
    } trap_cause_t;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcI      = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;
    localparam logic [2:0] F3Beq    = 3'b000;
    localparam logic [2:0] F3Bne    = 3'b001;

    typedef struct packed {
        logic        imem_req;
        logic        dmem_req;
        logic        dmem_we;
        logic        ir_load;
        logic        pc_wr;
        logic        pc_src;
        logic        a_wr;
        logic        b_wr;
        logic        aluout_wr;
        logic        mdr_wr;
        logic        rf_wr;
        logic        rf_src;
        sel_a_t      sel_a;
        sel_b_t      sel_b;
        alu_op_t     alu_op;
        logic        retire;
        logic        trap;
        trap_cause_t trap_cause;
    } ctl_t;

    typedef struct packed {
        logic    legal;
        alu_op_t op;
    } alu_dec_t;

    // Sub exists only for R-type; I-type ignores funct7_5 (no subi).
    function automatic alu_dec_t alu_decode(input logic [2:0] f3, input logic is_r,
                                            input logic f7_5);
        alu_dec_t d;
        d.legal = 1'b1;
        d.op    = AluAdd;
        case (f3)
            F3AddSub: d.op = (is_r && f7_5) ? AluSub : AluAdd;
            F3And:    d.op = AluAnd;
            F3Or:     d.op = AluOr;
            F3Xor:    d.op = AluXor;
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_bus_timer.sv
// mc_bus_timer: counts consecutive request cycles that go unanswered.
//   clk     in  clock, rising edge
//   rst     in  synchronous reset, active high
//   req     in  a bus request is outstanding this cycle
//   ack     in  the request is answered this cycle
//   expire  out request has waited TIMEOUT cycles with no ack (never when TIMEOUT = 0)
module mc_bus_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    output logic expire
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] Last = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

    logic [CntW-1:0] count_q;

    // Request states are never entered back to back without an ack, so clearing
    // whenever req is low is the same as clearing on entry to a request state.
    always_ff @(posedge clk) begin
        if (rst || !req || ack) begin
            count_q <= '0;
        end else if (count_q != Last) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire = (TIMEOUT != 0) && req && !ack && (count_q == Last);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control FSM for the RV64 datapath.
//   CLK, RST              clock (rising edge), synchronous active-high reset
//   opcode/funct3/funct7_5 IR fields
//   alu_zero              ULA zero flag (branch compare)
//   imem_ack, dmem_ack    memory handshake acknowledges
//   imem_req, dmem_req, dmem_we      memory requests
//   ir_load, pc_wr, pc_src, a_wr, b_wr, aluout_wr, mdr_wr, rf_wr, rf_src  datapath enables
//   sel_a, sel_b, alu_op  ULA operand/operation selects
//   retire                one-cycle pulse on the completing PC update
//   trap, trap_cause      TRAP indication and latched reason
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter bit          EN_BNE  = 1'b1,
    parameter bit          EN_LUI  = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_zero,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_load,
    output logic       pc_wr,
    output logic       pc_src,
    output logic       a_wr,
    output logic       b_wr,
    output logic       aluout_wr,
    output logic       mdr_wr,
    output logic       rf_wr,
    output logic       rf_src,
    output logic [1:0] sel_a,
    output logic [1:0] sel_b,
    output logic [2:0] alu_op,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_t      state_q, state_d;
    trap_cause_t cause_q, cause_d;
    ctl_t        ctl, ctl_out;
    alu_dec_t    dec;
    logic        bus_req, bus_ack, expire;

    // Timer sees state directly so expire never loops back through the decode.
    assign bus_req = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign bus_ack = (state_q == StFetch) ? imem_ack : dmem_ack;

    mc_bus_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (CLK),
        .rst    (RST),
        .req    (bus_req),
        .ack    (bus_ack),
        .expire (expire)
    );

    assign dec = alu_decode(funct3, state_q == StExecR, funct7_5);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StFetch;
            cause_q <= CauseNone;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        ctl     = '0;
        unique case (state_q)
            StFetch: begin
                ctl.imem_req = 1'b1;
                if (imem_ack) begin
                    ctl.ir_load = 1'b1;
                    state_d     = StDecode;
                end else if (expire) begin
                    state_d = StTrap;
                    cause_d = CauseImemTo;
                end
            end
            StDecode: begin
                // Branch target PC + (imm<<1) computed while PC still holds this instr.
                ctl.a_wr      = 1'b1;
                ctl.b_wr      = 1'b1;
                ctl.sel_a     = SelAPc;
                ctl.sel_b     = SelBImmSh1;
                ctl.alu_op    = AluAdd;
                ctl.aluout_wr = 1'b1;
                if (opcode == OpcR) begin
                    state_d = StExecR;
                end else if (opcode == OpcI) begin
                    state_d = StExecI;
                end else if (opcode == OpcLoad || opcode == OpcStore) begin
                    state_d = StAddr;
                end else if (opcode == OpcBranch) begin
                    state_d = StBranch;
                end else if (EN_LUI && opcode == OpcLui) begin
                    state_d = StLui;
                end else begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end
            end
            StExecR, StExecI: begin
                ctl.sel_a = SelAReg;
                ctl.sel_b = (state_q == StExecR) ? SelBReg : SelBImm;
                if (dec.legal) begin
                    ctl.alu_op    = dec.op;
                    ctl.aluout_wr = 1'b1;
                    state_d       = StWbAlu;
                end else begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end
            end
            StLui: begin
                ctl.sel_a     = SelAZero;
                ctl.sel_b     = SelBImm;
                ctl.alu_op    = AluAdd;
                ctl.aluout_wr = 1'b1;
                state_d       = StWbAlu;
            end
            StAddr: begin
                ctl.sel_a     = SelAReg;
                ctl.sel_b     = SelBImm;
                ctl.alu_op    = AluAdd;
                ctl.aluout_wr = 1'b1;
                state_d       = (opcode == OpcLoad) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                ctl.dmem_req = 1'b1;
                if (dmem_ack) begin
                    ctl.mdr_wr = 1'b1;
                    state_d    = StWbMem;
                end else if (expire) begin
                    state_d = StTrap;
                    cause_d = CauseDmemTo;
                end
            end
            StMemWr: begin
                ctl.dmem_req = 1'b1;
                ctl.dmem_we  = 1'b1;
                if (dmem_ack) begin
                    ctl.sel_a  = SelAPc;
                    ctl.sel_b  = SelBFour;
                    ctl.alu_op = AluAdd;
                    ctl.pc_wr  = 1'b1;
                    ctl.retire = 1'b1;
                    state_d    = StFetch;
                end else if (expire) begin
                    state_d = StTrap;
                    cause_d = CauseDmemTo;
                end
            end
            StWbAlu, StWbMem: begin
                ctl.rf_wr  = 1'b1;
                ctl.rf_src = (state_q == StWbMem);
                ctl.sel_a  = SelAPc;
                ctl.sel_b  = SelBFour;
                ctl.alu_op = AluAdd;
                ctl.pc_wr  = 1'b1;
                ctl.retire = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                ctl.sel_a  = SelAReg;
                ctl.sel_b  = SelBReg;
                ctl.alu_op = AluSub;
                if (funct3 == F3Beq || (EN_BNE && funct3 == F3Bne)) begin
                    // beq taken on equal, bne on not-equal.
                    if ((funct3 == F3Beq) ? alu_zero : !alu_zero) begin
                        ctl.pc_wr  = 1'b1;
                        ctl.pc_src = 1'b1;
                        ctl.retire = 1'b1;
                        state_d    = StFetch;
                    end else begin
                        state_d = StPcInc;
                    end
                end else begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end
            end
            StPcInc: begin
                ctl.sel_a  = SelAPc;
                ctl.sel_b  = SelBFour;
                ctl.alu_op = AluAdd;
                ctl.pc_wr  = 1'b1;
                ctl.retire = 1'b1;
                state_d    = StFetch;
            end
            StTrap: begin
                ctl.trap = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
        ctl.trap_cause = cause_q;
    end

    // Everything is forced low while RST is held, so a pending req drops immediately.
    assign ctl_out = RST ? '0 : ctl;

    assign imem_req   = ctl_out.imem_req;
    assign dmem_req   = ctl_out.dmem_req;
    assign dmem_we    = ctl_out.dmem_we;
    assign ir_load    = ctl_out.ir_load;
    assign pc_wr      = ctl_out.pc_wr;
    assign pc_src     = ctl_out.pc_src;
    assign a_wr       = ctl_out.a_wr;
    assign b_wr       = ctl_out.b_wr;
    assign aluout_wr  = ctl_out.aluout_wr;
    assign mdr_wr     = ctl_out.mdr_wr;
    assign rf_wr      = ctl_out.rf_wr;
    assign rf_src     = ctl_out.rf_src;
    assign sel_a      = ctl_out.sel_a;
    assign sel_b      = ctl_out.sel_b;
    assign alu_op     = ctl_out.alu_op;
    assign retire     = ctl_out.retire;
    assign trap       = ctl_out.trap;
    assign trap_cause = ctl_out.trap_cause;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed bench for mc_ctrl_fsm. Outputs are packed into one vector:
//   {imem_req,dmem_req,dmem_we,ir_load,pc_wr,pc_src,a_wr,b_wr,aluout_wr,mdr_wr,rf_wr,rf_src,
//    sel_a[1:0],sel_b[1:0],alu_op[2:0],retire,trap,trap_cause[1:0]}
// A second instance has EN_BNE=0 and EN_LUI=0.
module tb_mc_ctrl_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       alu_zero = 1'b0;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;

    logic       imem_req, dmem_req, dmem_we, ir_load, pc_wr, pc_src, a_wr, b_wr;
    logic       aluout_wr, mdr_wr, rf_wr, rf_src, retire, trap;
    logic [1:0] sel_a, sel_b, trap_cause;
    logic [2:0] alu_op;
    logic       n_imem_req, n_dmem_req, n_dmem_we, n_ir_load, n_pc_wr, n_pc_src, n_a_wr, n_b_wr;
    logic       n_aluout_wr, n_mdr_wr, n_rf_wr, n_rf_src, n_retire, n_trap;
    logic [1:0] n_sel_a, n_sel_b, n_trap_cause;
    logic [2:0] n_alu_op;

    logic [22:0] ctl, ctl_n;
    assign ctl = {imem_req, dmem_req, dmem_we, ir_load, pc_wr, pc_src, a_wr, b_wr, aluout_wr,
                  mdr_wr, rf_wr, rf_src, sel_a, sel_b, alu_op, retire, trap, trap_cause};
    assign ctl_n = {n_imem_req, n_dmem_req, n_dmem_we, n_ir_load, n_pc_wr, n_pc_src, n_a_wr,
                    n_b_wr, n_aluout_wr, n_mdr_wr, n_rf_wr, n_rf_src, n_sel_a, n_sel_b, n_alu_op,
                    n_retire, n_trap, n_trap_cause};

    localparam logic [22:0] VIdle      = 23'b0_0_0_0_0_0_0_0_0_0_0_0_00_00_000_0_0_00;
    localparam logic [22:0] VFetch     = 23'b1_0_0_0_0_0_0_0_0_0_0_0_00_00_000_0_0_00;
    localparam logic [22:0] VFetchAck  = 23'b1_0_0_1_0_0_0_0_0_0_0_0_00_00_000_0_0_00;
    localparam logic [22:0] VDecode    = 23'b0_0_0_0_0_0_1_1_1_0_0_0_00_11_000_0_0_00;
    localparam logic [22:0] VExecR     = 23'b0_0_0_0_0_0_0_0_1_0_0_0_01_00_000_0_0_00;
    localparam logic [22:0] VExecI     = 23'b0_0_0_0_0_0_0_0_1_0_0_0_01_10_000_0_0_00;
    localparam logic [22:0] VWbAlu     = 23'b0_0_0_0_1_0_0_0_0_0_1_0_00_01_000_1_0_00;
    localparam logic [22:0] VAddr      = 23'b0_0_0_0_0_0_0_0_1_0_0_0_01_10_000_0_0_00;
    localparam logic [22:0] VMemRd     = 23'b0_1_0_0_0_0_0_0_0_0_0_0_00_00_000_0_0_00;
    localparam logic [22:0] VMemRdAck  = 23'b0_1_0_0_0_0_0_0_0_1_0_0_00_00_000_0_0_00;
    localparam logic [22:0] VWbMem     = 23'b0_0_0_0_1_0_0_0_0_0_1_1_00_01_000_1_0_00;
    localparam logic [22:0] VMemWr     = 23'b0_1_1_0_0_0_0_0_0_0_0_0_00_00_000_0_0_00;
    localparam logic [22:0] VMemWrAck  = 23'b0_1_1_0_1_0_0_0_0_0_0_0_00_01_000_1_0_00;
    localparam logic [22:0] VBrTaken   = 23'b0_0_0_0_1_1_0_0_0_0_0_0_01_00_001_1_0_00;
    localparam logic [22:0] VBrNot     = 23'b0_0_0_0_0_0_0_0_0_0_0_0_01_00_001_0_0_00;
    localparam logic [22:0] VPcInc     = 23'b0_0_0_0_1_0_0_0_0_0_0_0_00_01_000_1_0_00;
    localparam logic [22:0] VLui       = 23'b0_0_0_0_0_0_0_0_1_0_0_0_10_10_000_0_0_00;
    localparam logic [22:0] VTrapIll   = 23'b0_0_0_0_0_0_0_0_0_0_0_0_00_00_000_0_1_01;
    localparam logic [22:0] VTrapImem  = 23'b0_0_0_0_0_0_0_0_0_0_0_0_00_00_000_0_1_10;
    localparam logic [22:0] VTrapDmem  = 23'b0_0_0_0_0_0_0_0_0_0_0_0_00_00_000_0_1_11;

    int checks = 0;
    int passes = 0;

    always #5 CLK = ~CLK;

    mc_ctrl_fsm #(.TIMEOUT(16), .EN_BNE(1'b1), .EN_LUI(1'b1)) dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .alu_zero(alu_zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_load(ir_load),
        .pc_wr(pc_wr), .pc_src(pc_src), .a_wr(a_wr), .b_wr(b_wr), .aluout_wr(aluout_wr),
        .mdr_wr(mdr_wr), .rf_wr(rf_wr), .rf_src(rf_src), .sel_a(sel_a), .sel_b(sel_b),
        .alu_op(alu_op), .retire(retire), .trap(trap), .trap_cause(trap_cause)
    );

    mc_ctrl_fsm #(.TIMEOUT(16), .EN_BNE(1'b0), .EN_LUI(1'b0)) dut_n (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .alu_zero(alu_zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(n_imem_req), .dmem_req(n_dmem_req), .dmem_we(n_dmem_we),
        .ir_load(n_ir_load), .pc_wr(n_pc_wr), .pc_src(n_pc_src), .a_wr(n_a_wr),
        .b_wr(n_b_wr), .aluout_wr(n_aluout_wr), .mdr_wr(n_mdr_wr), .rf_wr(n_rf_wr),
        .rf_src(n_rf_src), .sel_a(n_sel_a), .sel_b(n_sel_b), .alu_op(n_alu_op),
        .retire(n_retire), .trap(n_trap), .trap_cause(n_trap_cause)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench 1 time unit after the reset edge, DUT in FETCH.
    task automatic do_reset();
        RST = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        alu_zero = 1'b0;
        cyc();
        RST = 1'b0;
    endtask

    // Fetch (ack immediate) then decode; leaves the DUT one edge into the dispatched state.
    task automatic fetch_decode(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        do_reset();
        opcode = opc;
        funct3 = f3;
        funct7_5 = f7;
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        cyc();
        #2;
        checks++;
        if (ctl !== VIdle) $display("FAIL reset_outputs: got %b want %b", ctl, VIdle);
        else passes++;
        RST = 1'b0;
        #1;
        checks++;
        if (ctl !== VFetch) $display("FAIL reset_fetch: got %b want %b", ctl, VFetch);
        else passes++;
    endtask

    task automatic test_add();
        logic [22:0] exp_seq [5];
        exp_seq[0] = VFetchAck;
        exp_seq[1] = VDecode;
        exp_seq[2] = VExecR;
        exp_seq[3] = VWbAlu;
        exp_seq[4] = VFetch;
        do_reset();
        opcode = 7'b0110011;
        funct3 = 3'b000;
        funct7_5 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            imem_ack = (i == 0);
            #2;
            checks++;
            if (ctl !== exp_seq[i])
                $display("FAIL add_cycle%0d: got %b want %b", i + 1, ctl, exp_seq[i]);
            else passes++;
            cyc();
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0]  opc [7];
        logic [2:0]  f3  [7];
        logic        f7  [7];
        logic [22:0] ex  [7];
        logic        ok  [7];
        logic [22:0] after;
        opc[0] = 7'b0110011; f3[0] = 3'b000; f7[0] = 1'b1; ex[0] = VExecR | 23'(3'b001 << 4); ok[0] = 1;
        opc[1] = 7'b0110011; f3[1] = 3'b111; f7[1] = 1'b0; ex[1] = VExecR | 23'(3'b010 << 4); ok[1] = 1;
        opc[2] = 7'b0110011; f3[2] = 3'b110; f7[2] = 1'b0; ex[2] = VExecR | 23'(3'b011 << 4); ok[2] = 1;
        opc[3] = 7'b0010011; f3[3] = 3'b100; f7[3] = 1'b0; ex[3] = VExecI | 23'(3'b100 << 4); ok[3] = 1;
        opc[4] = 7'b0010011; f3[4] = 3'b000; f7[4] = 1'b1; ex[4] = VExecI;                   ok[4] = 1;
        opc[5] = 7'b0110011; f3[5] = 3'b001; f7[5] = 1'b0; ex[5] = VIdle;                    ok[5] = 0;
        opc[6] = 7'b0010011; f3[6] = 3'b010; f7[6] = 1'b0; ex[6] = VIdle;                    ok[6] = 0;
        for (int i = 0; i < 7; i++) begin
            fetch_decode(opc[i], f3[i], f7[i]);
            #2;
            if (ok[i]) begin
                checks++;
                if (ctl !== ex[i]) $display("FAIL alu_exec%0d: got %b want %b", i, ctl, ex[i]);
                else passes++;
            end
            cyc();
            #2;
            after = ok[i] ? VWbAlu : VTrapIll;
            checks++;
            if (ctl !== after) $display("FAIL alu_next%0d: got %b want %b", i, ctl, after);
            else passes++;
        end
    endtask

    task automatic test_ld_wait();
        fetch_decode(7'b0000011, 3'b011, 1'b0);
        #2;
        checks++;
        if (ctl !== VAddr) $display("FAIL ld_addr: got %b want %b", ctl, VAddr);
        else passes++;
        cyc();
        for (int i = 0; i < 6; i++) begin
            dmem_ack = (i == 5);
            #2;
            checks++;
            if (ctl !== (i == 5 ? VMemRdAck : VMemRd))
                $display("FAIL ld_memrd%0d: got %b want %b", i, ctl,
                         (i == 5 ? VMemRdAck : VMemRd));
            else passes++;
            cyc();
        end
        dmem_ack = 1'b0;
        #2;
        checks++;
        if (ctl !== VWbMem) $display("FAIL ld_wbmem: got %b want %b", ctl, VWbMem);
        else passes++;
    endtask

    task automatic test_imem_timeout();
        int n;
        n = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            #2;
            if (trap) break;
            if (imem_req) n++;
            cyc();
        end
        checks++;
        if (n != 16) $display("FAIL imem_to_reqs: got %0d want 16", n);
        else passes++;
        checks++;
        if (ctl !== VTrapImem) $display("FAIL imem_to_trap: got %b want %b", ctl, VTrapImem);
        else passes++;
        imem_ack = 1'b1;
        cyc();
        cyc();
        #2;
        checks++;
        if (ctl !== VTrapImem) $display("FAIL imem_to_held: got %b want %b", ctl, VTrapImem);
        else passes++;
        imem_ack = 1'b0;
        RST = 1'b1;
        #1;
        checks++;
        if (ctl !== VIdle) $display("FAIL trap_rst_outputs: got %b want %b", ctl, VIdle);
        else passes++;
        cyc();
        RST = 1'b0;
        #2;
        checks++;
        if (ctl !== VFetch) $display("FAIL trap_rst_fetch: got %b want %b", ctl, VFetch);
        else passes++;
    endtask

    task automatic test_ack_wins();
        do_reset();
        opcode = 7'b0110011;
        funct3 = 3'b000;
        repeat (15) cyc();
        imem_ack = 1'b1;
        #2;
        checks++;
        if (ctl !== VFetchAck) $display("FAIL ack_last_fetch: got %b want %b", ctl, VFetchAck);
        else passes++;
        cyc();
        imem_ack = 1'b0;
        #2;
        checks++;
        if (ctl !== VDecode) $display("FAIL ack_last_decode: got %b want %b", ctl, VDecode);
        else passes++;
    endtask

    task automatic test_branch();
        // beq, equal -> taken in cycle 3
        fetch_decode(7'b1100011, 3'b000, 1'b0);
        alu_zero = 1'b1;
        #2;
        checks++;
        if (ctl !== VBrTaken) $display("FAIL beq_taken: got %b want %b", ctl, VBrTaken);
        else passes++;
        cyc();
        #2;
        checks++;
        if (ctl !== VFetch) $display("FAIL beq_refetch: got %b want %b", ctl, VFetch);
        else passes++;
        // bne, equal -> not taken, PC_INC in cycle 4; EN_BNE=0 instance traps
        fetch_decode(7'b1100011, 3'b001, 1'b0);
        alu_zero = 1'b1;
        #2;
        checks++;
        if (ctl !== VBrNot) $display("FAIL bne_not_taken: got %b want %b", ctl, VBrNot);
        else passes++;
        cyc();
        #2;
        checks++;
        if (ctl !== VPcInc) $display("FAIL bne_pcinc: got %b want %b", ctl, VPcInc);
        else passes++;
        checks++;
        if (ctl_n !== VTrapIll) $display("FAIL bne_disabled: got %b want %b", ctl_n, VTrapIll);
        else passes++;
        // bne, not equal -> taken; beq not equal -> not taken
        fetch_decode(7'b1100011, 3'b001, 1'b0);
        alu_zero = 1'b0;
        #2;
        checks++;
        if (ctl !== VBrTaken) $display("FAIL bne_taken: got %b want %b", ctl, VBrTaken);
        else passes++;
        fetch_decode(7'b1100011, 3'b000, 1'b0);
        alu_zero = 1'b0;
        #2;
        checks++;
        if (ctl !== VBrNot) $display("FAIL beq_not_taken: got %b want %b", ctl, VBrNot);
        else passes++;
        // unsupported funct3
        fetch_decode(7'b1100011, 3'b100, 1'b0);
        cyc();
        #2;
        checks++;
        if (ctl !== VTrapIll) $display("FAIL branch_illegal: got %b want %b", ctl, VTrapIll);
        else passes++;
    endtask

    task automatic test_illegal();
        do_reset();
        opcode = 7'b1111111;
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        #2;
        checks++;
        if (ctl !== VDecode) $display("FAIL illegal_decode: got %b want %b", ctl, VDecode);
        else passes++;
        cyc();
        #2;
        checks++;
        if (ctl !== VTrapIll) $display("FAIL illegal_trap: got %b want %b", ctl, VTrapIll);
        else passes++;
        fetch_decode(7'b0110111, 3'b000, 1'b0);
        #2;
        checks++;
        if (ctl !== VLui) $display("FAIL lui_exec: got %b want %b", ctl, VLui);
        else passes++;
        checks++;
        if (ctl_n !== VTrapIll) $display("FAIL lui_disabled: got %b want %b", ctl_n, VTrapIll);
        else passes++;
        cyc();
        #2;
        checks++;
        if (ctl !== VWbAlu) $display("FAIL lui_wb: got %b want %b", ctl, VWbAlu);
        else passes++;
    endtask

    task automatic test_store();
        int n;
        fetch_decode(7'b0100011, 3'b011, 1'b0);
        cyc();
        dmem_ack = 1'b1;
        #2;
        checks++;
        if (ctl !== VMemWrAck) $display("FAIL sd_ack: got %b want %b", ctl, VMemWrAck);
        else passes++;
        cyc();
        dmem_ack = 1'b0;
        #2;
        checks++;
        if (ctl !== VFetch) $display("FAIL sd_refetch: got %b want %b", ctl, VFetch);
        else passes++;
        // reset while the write is pending
        fetch_decode(7'b0100011, 3'b011, 1'b0);
        cyc();
        #2;
        checks++;
        if (ctl !== VMemWr) $display("FAIL sd_pending: got %b want %b", ctl, VMemWr);
        else passes++;
        RST = 1'b1;
        #1;
        checks++;
        if (ctl !== VIdle) $display("FAIL sd_rst_drop: got %b want %b", ctl, VIdle);
        else passes++;
        cyc();
        RST = 1'b0;
        #2;
        checks++;
        if (ctl !== VFetch) $display("FAIL sd_rst_fetch: got %b want %b", ctl, VFetch);
        else passes++;
        // data-side timeout
        fetch_decode(7'b0100011, 3'b011, 1'b0);
        cyc();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (trap) break;
            if (dmem_req) n++;
            cyc();
        end
        checks++;
        if (n != 16) $display("FAIL dmem_to_reqs: got %0d want 16", n);
        else passes++;
        checks++;
        if (ctl !== VTrapDmem) $display("FAIL dmem_to_trap: got %b want %b", ctl, VTrapDmem);
        else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_ld_wait();
        test_imem_timeout();
        test_ack_wins();
        test_branch();
        test_illegal();
        test_store();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
